dram_responder: RTL

Device-side responder for the off-chip DRAM pin interface driven by the system's DRAM controller wrapper. It decodes CSn/RASn/CASn/WEn commands against a single-bank row/column model, enforces activate, CAS and precharge timing, and returns read data with a one-cycle valid pulse. It sits on the far side of the `DRAM_*` top-level pins, so the DRAM controller path can be closed and exercised in simulation and FPGA builds without an external memory model.

---
 rtl/dram_resp_pkg.sv | 38 +++
 rtl/dram_bank_timer.sv | 28 ++
 rtl/dram_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dram_resp_pkg.sv
// Shared types and command decode for the DRAM pin-interface responder.
package dram_resp_pkg;

  localparam int DATA_BITS = 32;
  localparam int NUM_BYTES = DATA_BITS / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVATING,
    ACTIVE,
    PRECHARGING
  } state_e;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    PRE,
    RD,
    WR
  } cmd_e;

  // Map the raw strobes onto a command; any unlisted encoding is a NOP.
  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic [NUM_BYTES-1:0] wen);
    cmd_e cmd;
    cmd = NOP;
    if (!csn) begin
      if (!rasn && casn) begin
        if (wen == '1)      cmd = ACT;
        else if (wen == '0) cmd = PRE;
      end else if (rasn && !casn) begin
        cmd = (wen == '1) ? RD : WR;
      end
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// Loadable down-counter shared by the activate (RCD) and precharge (RP) waits.
module dram_bank_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/dram_responder.sv
// Single-bank DRAM device model: command decode, timing checks,
// byte-masked backing store and fixed-latency read return.
module dram_responder
  import dram_resp_pkg::*;
#(
  parameter int ROW_BITS   = 11,
  parameter int COL_BITS   = 10,
  parameter int STORE_BITS = 12,
  parameter int RCD        = 5,
  parameter int CAS_LAT    = 5,
  parameter int RP         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DRAM_CSn,
  input  logic [NUM_BYTES-1:0] DRAM_WEn,
  input  logic                 DRAM_RASn,
  input  logic                 DRAM_CASn,
  input  logic [ROW_BITS-1:0]  DRAM_A,
  input  logic [DATA_BITS-1:0] DRAM_D,
  output logic [DATA_BITS-1:0] DRAM_Q,
  output logic                 DRAM_valid,
  output logic                 protocol_err
);

  localparam int TIMER_BITS = $clog2(((RCD > RP) ? RCD : RP) + 1);
  localparam int LAT_BITS   = $clog2(CAS_LAT + 1);

  state_e                r_state;
  state_e                w_state;
  logic [ROW_BITS-1:0]   r_row;
  cmd_e                  w_cmd;
  logic                  w_timer_load;
  logic [TIMER_BITS-1:0] w_timer_value;
  logic                  w_timer_done;

  logic                  r_rd_pending;
  logic [LAT_BITS-1:0]   r_rd_cnt;
  logic [DATA_BITS-1:0]  r_rd_data;
  logic                  w_rd_issue;
  logic                  w_rd_busy;

  logic                  w_act_ok;
  logic                  w_pre_ok;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_illegal;
  logic [STORE_BITS-1:0] w_idx;

  logic [DATA_BITS-1:0]  r_mem [2**STORE_BITS];

  assign w_cmd = decode_cmd(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);

  // An expired timer completes its phase on the same edge, so a command
  // sampled then sees the destination state.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state unassigned (no latch).
    w_state = r_state;
    if (r_state == ACTIVATING && w_timer_done)  w_state = ACTIVE;
    if (r_state == PRECHARGING && w_timer_done) w_state = IDLE;
  end

  // The response slot frees up on the edge it is delivered, allowing back-to-back reads.
  assign w_rd_issue = r_rd_pending && (r_rd_cnt == '0);
  assign w_rd_busy  = r_rd_pending && !w_rd_issue;

  assign w_act_ok  = (w_cmd == ACT) && (w_state == IDLE);
  assign w_pre_ok  = (w_cmd == PRE) && (w_state == ACTIVE);
  assign w_rd_ok   = (w_cmd == RD)  && (w_state == ACTIVE) && !w_rd_busy;
  assign w_wr_ok   = (w_cmd == WR)  && (w_state == ACTIVE);
  assign w_illegal = (w_cmd != NOP) && !(w_act_ok || w_pre_ok || w_rd_ok || w_wr_ok);

  assign w_timer_load  = w_act_ok || w_pre_ok;
  assign w_timer_value = w_act_ok ? TIMER_BITS'(RCD - 1) : TIMER_BITS'(RP - 1);

  // Row bits above the store depth alias silently.
  assign w_idx = STORE_BITS'({r_row, DRAM_A[COL_BITS-1:0]});

  dram_bank_timer #(
    .WIDTH(TIMER_BITS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_timer_load),
    .value(w_timer_value),
    .done (w_timer_done)
  );

  // Bank FSM, open-row latch and sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_row        <= '0;
      protocol_err <= 1'b0;
    end else begin
      r_state <= w_state;
      if (w_act_ok) begin
        r_state <= ACTIVATING;
        r_row   <= DRAM_A;
      end
      if (w_pre_ok) r_state <= PRECHARGING;
      if (w_illegal) protocol_err <= 1'b1;
    end
  end

  // Read latency pipeline: capture at the RD edge, deliver CAS_LAT edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_rd_cnt     <= '0;
      r_rd_data    <= '0;
      DRAM_Q       <= '0;
      DRAM_valid   <= 1'b0;
    end else begin
      DRAM_valid <= 1'b0;
      if (w_rd_issue) begin
        DRAM_Q       <= r_rd_data;
        DRAM_valid   <= 1'b1;
        r_rd_pending <= 1'b0;
      end else if (r_rd_pending) begin
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_pending <= 1'b1;
        r_rd_cnt     <= LAT_BITS'(CAS_LAT - 1);
        r_rd_data    <= r_mem[w_idx];
      end
    end
  end

  // Byte-masked write into the backing store.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive rst and it maps onto block RAM.
    if (w_wr_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (!DRAM_WEn[i]) r_mem[w_idx][8*i +: 8] <= DRAM_D[8*i +: 8];
      end
    end
  end

endmodule
